// File: rtl/multicycle_control_unit_if.sv
// Bus between the multicycle control unit and its datapath/instruction memory.
// master = control unit side, slave = datapath/memory side.
interface multicycle_control_unit_if #(
   parameter int INSTR_W = 9,
   parameter int ALUOP_W = 3,
   parameter int CNT_W   = 32
);
   logic [INSTR_W-1:0] instr;
   logic               instr_valid;
   logic               zero_flag;
   logic               instr_req;
   logic               jump;
   logic               mem_read;
   logic               mem_write;
   logic               reg_write;
   logic [ALUOP_W-1:0] alu_op;
   logic               alu_src_imm;
   logic               pc_en;
   logic               done;
   logic [CNT_W-1:0]   cycle_count;
   logic [CNT_W-1:0]   instr_count;

   modport master (
      input  instr, instr_valid, zero_flag,
      output instr_req, jump, mem_read, mem_write, reg_write,
             alu_op, alu_src_imm, pc_en, done, cycle_count, instr_count
   );

   modport slave (
      output instr, instr_valid, zero_flag,
      input  instr_req, jump, mem_read, mem_write, reg_write,
             alu_op, alu_src_imm, pc_en, done, cycle_count, instr_count
   );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller with HALT and variable load latency.
// Optional performance counters enabled by defining CTRL_PERF_CNT_EN.
module multicycle_control_unit #(
   parameter int INSTR_W = 9,
   parameter int ALUOP_W = 3,
   parameter int MEM_LAT = 1,
   parameter int CNT_W   = 32
) (
   input logic                    clk,
   input logic                    reset,
   multicycle_control_unit_if.master bus
);
   localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   typedef enum logic [2:0] {
      FETCH, DECODE, EXEC, MEM, WB, HALT
   } state_t;

   state_t             state, state_d;
   logic [INSTR_W-1:0] ir, ir_d;
   logic [ALUOP_W-1:0] aluop_q, aluop_d;
   logic               imm_q, imm_d;
   logic [LAT_W-1:0]   lat, lat_d;

   logic [1:0] t;
   logic [2:0] f;
   logic       is_halt;
   logic       req_i, jump_i, rd_i, wr_i, rw_i, pc_i, done_i;

   assign t       = ir[INSTR_W-1 -: 2];
   assign f       = ir[INSTR_W-3 -: 3];
   assign is_halt = (t == 2'b11) && (&ir[INSTR_W-3:0]);

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= FETCH;
         ir      <= '0;
         lat     <= '0;
         aluop_q <= '0;
         imm_q   <= 1'b0;
      end else begin
         state   <= state_d;
         ir      <= ir_d;
         lat     <= lat_d;
         aluop_q <= aluop_d;
         imm_q   <= imm_d;
      end
   end

   always_comb begin
      state_d = state;
      ir_d    = ir;
      lat_d   = lat;
      aluop_d = aluop_q;
      imm_d   = imm_q;
      req_i   = 1'b0;
      jump_i  = 1'b0;
      rd_i    = 1'b0;
      wr_i    = 1'b0;
      rw_i    = 1'b0;
      pc_i    = 1'b0;
      done_i  = 1'b0;
      case (state)
         FETCH: begin
            req_i = 1'b1;
            if (bus.instr_valid) begin
               ir_d    = bus.instr;
               state_d = DECODE;
            end
         end
         DECODE: begin
            case (t)
               2'b00:   begin aluop_d = ALUOP_W'(f);      imm_d = 1'b0; end
               2'b01:   begin aluop_d = ALUOP_W'(3'b000); imm_d = 1'b1; end
               2'b10:   begin aluop_d = ALUOP_W'(3'b001); imm_d = 1'b0; end
               default: begin aluop_d = ALUOP_W'(f);      imm_d = 1'b1; end
            endcase
            state_d = EXEC;
         end
         EXEC: begin
            lat_d = '0;
            case (t)
               2'b01: state_d = MEM;
               2'b10: begin
                  // f[2] selects BNEZ (jump on non-zero) over BEQZ
                  jump_i  = f[2] ? ~bus.zero_flag : bus.zero_flag;
                  pc_i    = 1'b1;
                  state_d = FETCH;
               end
               2'b11:   state_d = is_halt ? HALT : WB;
               default: state_d = WB;
            endcase
         end
         MEM: begin
            if (f[2]) begin
               rd_i = 1'b1;
               if (lat == LAT_W'(MEM_LAT - 1)) begin
                  lat_d   = '0;
                  state_d = WB;
               end else begin
                  lat_d = lat + 1'b1;
               end
            end else begin
               wr_i    = 1'b1;
               pc_i    = 1'b1;
               state_d = FETCH;
            end
         end
         WB: begin
            rw_i    = 1'b1;
            pc_i    = 1'b1;
            state_d = FETCH;
         end
         HALT:    done_i  = 1'b1;
         default: state_d = FETCH;
      endcase
   end

   // Outputs are forced low during the reset cycle itself, not just after it.
   assign bus.instr_req   = req_i  & ~reset;
   assign bus.jump        = jump_i & ~reset;
   assign bus.mem_read    = rd_i   & ~reset;
   assign bus.mem_write   = wr_i   & ~reset;
   assign bus.reg_write   = rw_i   & ~reset;
   assign bus.pc_en       = pc_i   & ~reset;
   assign bus.done        = done_i & ~reset;
   assign bus.alu_op      = reset ? '0 : aluop_q;
   assign bus.alu_src_imm = imm_q  & ~reset;

`ifdef CTRL_PERF_CNT_EN
   logic [CNT_W-1:0] cyc_q, ins_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         cyc_q <= '0;
         ins_q <= '0;
      end else begin
         if (state != HALT)
            cyc_q <= cyc_q + 1'b1;
         if (pc_i || (state == EXEC && state_d == HALT))
            ins_q <= ins_q + 1'b1;
      end
   end

   assign bus.cycle_count = cyc_q;
   assign bus.instr_count = ins_q;
`else
   assign bus.cycle_count = '0;
   assign bus.instr_count = '0;
`endif
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: stimulus pushes expected strobe
// events (cycle offset from accept + strobe vector), a negedge monitor pops and compares.
module tb_multicycle_control_unit;
   localparam int INSTR_W = 9;
   localparam int ALUOP_W = 3;
   localparam int MEM_LAT = 3;
   localparam int CNT_W   = 32;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   multicycle_control_unit_if #(.INSTR_W(INSTR_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) bus ();

   multicycle_control_unit #(
      .INSTR_W(INSTR_W), .ALUOP_W(ALUOP_W), .MEM_LAT(MEM_LAT), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   typedef struct {
      string      name;
      int         off;
      logic [9:0] vec;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   int   ncyc  = 0;
   int   acc   = 0;
   logic done_prev = 1'b0;
   logic [CNT_W-1:0] mcyc = '0;

   // vec = {jump, mem_read, mem_write, reg_write, pc_en, done, alu_op[2:0], alu_src_imm}
   function automatic logic [9:0] mk(logic j, logic mr, logic mw, logic rw, logic pc,
                                     logic dn, logic [2:0] alu, logic imm);
      return {j, mr, mw, rw, pc, dn, alu, imm};
   endfunction

   task automatic push(string n, int off, logic [9:0] v);
      exp_t e;
      e.name = n; e.off = off; e.vec = v;
      q.push_back(e);
   endtask

   task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   // cycles while out of reset and not halted
   always @(posedge clk) begin
      if (reset) mcyc <= '0;
      else if (!bus.done) mcyc <= mcyc + 1'b1;
   end

   always @(negedge clk) begin
      logic [9:0] v;
      int off;
      exp_t e;
      ncyc++;
      if (!reset && bus.instr_req && bus.instr_valid) acc = ncyc;
      v = {bus.jump, bus.mem_read, bus.mem_write, bus.reg_write, bus.pc_en,
           bus.done, bus.alu_op, bus.alu_src_imm};
      if (bus.jump || bus.mem_read || bus.mem_write || bus.reg_write || bus.pc_en ||
          (bus.done && !done_prev)) begin
         total++;
         off = ncyc - acc + 1;
         if (q.size() == 0) begin
            bad++;
            $display("FAIL spurious: got vec=%b at offset %0d, expected no strobe", v, off);
         end else begin
            e = q.pop_front();
            if (e.off != off || e.vec !== v) begin
               bad++;
               $display("FAIL %s: got vec=%b off=%0d expected vec=%b off=%0d",
                        e.name, v, off, e.vec, e.off);
            end
         end
      end
      done_prev = bus.done;
   end

   task automatic start(logic [8:0] ins, logic zf);
      int n;
      @(posedge clk); #1;
      bus.zero_flag   = zf;
      bus.instr       = ins;
      bus.instr_valid = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (bus.instr_req) break;
         n++;
         if (n > 50) begin
            total++; bad++;
            $display("FAIL accept_timeout: got no instr_req expected instr_req=1");
            break;
         end
      end
      @(posedge clk); #1;
      bus.instr_valid = 1'b0;
      bus.instr       = '0;
   endtask

   task automatic issue(logic [8:0] ins, logic zf);
      int n;
      start(ins, zf);
      n = 0;
      forever begin
         @(negedge clk);
         if (bus.instr_req || bus.done) break;
         n++;
         if (n > 50) begin
            total++; bad++;
            $display("FAIL complete_timeout: got no return to FETCH expected FETCH or HALT");
            break;
         end
      end
   endtask

   initial begin
      bus.instr       = '0;
      bus.instr_valid = 1'b0;
      bus.zero_flag   = 1'b0;
      reset           = 1'b1;

      @(negedge clk);
      chk("reset_req",  bus.instr_req, 0);
      chk("reset_done", bus.done, 0);
      chk("reset_alu",  bus.alu_op, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("req_after_reset", bus.instr_req, 1);

      push("r_wb", 4, mk(0,0,0,1,1,0,3'b101,0));
      issue(9'b00_101_0000, 1'b0);

      for (int i = 0; i < MEM_LAT; i++) push("ld_rd", 4 + i, mk(0,1,0,0,0,0,3'b000,1));
      push("ld_wb", 7, mk(0,0,0,1,1,0,3'b000,1));
      issue(9'b01_100_0000, 1'b0);

      push("st_wr", 4, mk(0,0,1,0,1,0,3'b000,1));
      issue(9'b01_000_0000, 1'b0);

      push("beqz_z1", 3, mk(1,0,0,0,1,0,3'b001,0));
      issue(9'b10_000_0000, 1'b1);
      push("beqz_z0", 3, mk(0,0,0,0,1,0,3'b001,0));
      issue(9'b10_000_0000, 1'b0);
      push("bnez_z0", 3, mk(1,0,0,0,1,0,3'b001,0));
      issue(9'b10_100_0000, 1'b0);
      push("bnez_z1", 3, mk(0,0,0,0,1,0,3'b001,0));
      issue(9'b10_100_0000, 1'b1);

      push("s_wb", 4, mk(0,0,0,1,1,0,3'b010,1));
      issue(9'b11_010_0001, 1'b0);

      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("fetch_hold_req", bus.instr_req, 1);
      end

      // abort a load in its second MEM cycle
      push("abort_rd", 4, mk(0,1,0,0,0,0,3'b000,1));
      start(9'b01_100_0000, 1'b0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("abort_cyc_clr", bus.cycle_count, 0);
      chk("abort_ins_clr", bus.instr_count, 0);
      @(posedge clk);
      #1 reset = 1'b0;

      push("p_r",   4, mk(0,0,0,1,1,0,3'b011,0));
      issue(9'b00_011_0000, 1'b0);
      for (int i = 0; i < MEM_LAT; i++) push("p_ld_rd", 4 + i, mk(0,1,0,0,0,0,3'b000,1));
      push("p_ld_wb", 7, mk(0,0,0,1,1,0,3'b000,1));
      issue(9'b01_100_0000, 1'b0);
      push("p_br",  3, mk(1,0,0,0,1,0,3'b001,0));
      issue(9'b10_000_0000, 1'b1);
      push("halt",  4, mk(0,0,0,0,0,1,3'b111,1));
      issue(9'b11_111_1111, 1'b0);

      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("halt_done", bus.done, 1);
         chk("halt_req",  bus.instr_req, 0);
      end
`ifdef CTRL_PERF_CNT_EN
      chk("perf_instr", bus.instr_count, 4);
      chk("perf_cyc_a", bus.cycle_count, mcyc);
      repeat (3) @(negedge clk);
      chk("perf_cyc_b", bus.cycle_count, mcyc);
`else
      chk("perf_off_cyc", bus.cycle_count, 0);
      chk("perf_off_ins", bus.instr_count, 0);
`endif

      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      chk("rst_halt_done", bus.done, 0);
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("post_halt_req",  bus.instr_req, 1);
      chk("post_halt_done", bus.done, 0);

      repeat (2) @(negedge clk);
      chk("queue_empty", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
